// File: rtl/vote_tally_core.sv
// rtl/vote_tally_core.sv - ballot tally engine with election-phase FSM and winner scan
//
// Purpose: counts one-hot ballots per candidate with saturating counters,
// counts rejected ballots, closes the vote on command or at a ballot limit,
// then scans the counters one per cycle to produce a one-hot winner and tie flag.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   cmd_valid_i     qualifies cmd_i for one cycle
//   cmd_i           00=OPEN 01=CLOSE 10=CLEAR 11=NOP
//   ballot_valid_i  a ballot is presented
//   ballot_i        one-hot candidate select
//   ballot_ready_o  high exactly while state is OPEN
//   rd_idx_i        counter read-back select
//   rd_count_o      registered counter value for rd_idx_i (1-cycle latency)
//   state_o         00=IDLE 01=OPEN 10=TALLY 11=DONE
//   total_o         accepted ballots
//   rejected_o      rejected ballots, saturating
//   winner_o        one-hot winner, 0 on no votes or tie
//   tie_o           two or more candidates share a nonzero maximum
//   result_valid_o  high exactly while state is DONE
module vote_tally_core #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int MAX_BALLOTS = 200,
    localparam int IDX_W      = $clog2(NUM_CAND),
    localparam int TOT_W      = CNT_W + IDX_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    input  logic [1:0]          cmd_i,
    input  logic                ballot_valid_i,
    input  logic [NUM_CAND-1:0] ballot_i,
    output logic                ballot_ready_o,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic [CNT_W-1:0]    rd_count_o,
    output logic [1:0]          state_o,
    output logic [TOT_W-1:0]    total_o,
    output logic [CNT_W-1:0]    rejected_o,
    output logic [NUM_CAND-1:0] winner_o,
    output logic                tie_o,
    output logic                result_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OPEN  = 2'b01,
        ST_TALLY = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0]         CMD_OPEN  = 2'b00;
    localparam logic [1:0]         CMD_CLOSE = 2'b01;
    localparam logic [1:0]         CMD_CLEAR = 2'b10;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [TOT_W-1:0]   MAX_T     = TOT_W'(MAX_BALLOTS);
    localparam logic [IDX_W:0]     SCAN_END  = (IDX_W+1)'(NUM_CAND);
    localparam logic [IDX_W:0]     NUM_C     = (IDX_W+1)'(NUM_CAND);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q [NUM_CAND];
    logic [CNT_W-1:0]      cnt_d [NUM_CAND];
    logic [TOT_W-1:0]      total_q, total_d;
    logic [CNT_W-1:0]      rej_q, rej_d;
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic [NUM_CAND-1:0]   winner_q, winner_d;
    logic                  tie_q, tie_d;
    // Scan position runs 0..NUM_CAND; the extra value is the result-load cycle.
    logic [IDX_W:0]        scan_cnt_q, scan_cnt_d;
    logic [CNT_W-1:0]      max_q, max_d;
    logic [IDX_W-1:0]      max_idx_q, max_idx_d;
    logic                  scan_tie_q, scan_tie_d;

    logic                  cmd_open, cmd_close, cmd_clear;
    logic                  bal_onehot;
    logic [IDX_W-1:0]      bal_idx;
    logic [CNT_W-1:0]      scan_val;
    logic [IDX_W-1:0]      scan_idx;
    logic                  auto_close;

    assign cmd_open  = cmd_valid_i && (cmd_i == CMD_OPEN);
    assign cmd_close = cmd_valid_i && (cmd_i == CMD_CLOSE);
    assign cmd_clear = cmd_valid_i && (cmd_i == CMD_CLEAR);

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign bal_onehot = (ballot_i != '0) && ((ballot_i & (ballot_i - 1'b1)) == '0);
    assign scan_idx   = scan_cnt_q[IDX_W-1:0];

    always_comb begin
        bal_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (ballot_i[i]) begin
                bal_idx = IDX_W'(i);
            end
        end
    end

    // Read-back is independent of the FSM so counters stay visible in every state.
    always_comb begin
        rd_count_d = '0;
        if ({1'b0, rd_idx_i} < NUM_C) begin
            rd_count_d = cnt_q[rd_idx_i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        rej_d      = rej_q;
        winner_d   = winner_q;
        tie_d      = tie_q;
        scan_cnt_d = scan_cnt_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        scan_tie_d = scan_tie_q;
        scan_val   = '0;
        auto_close = 1'b0;

        if (cmd_clear) begin
            // CLEAR outranks everything, including a ballot in the same cycle.
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt_d[i] = '0;
            end
            total_d  = '0;
            rej_d    = '0;
            winner_d = '0;
            tie_d    = 1'b0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_open) begin
                        state_d = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (ballot_valid_i) begin
                        if (bal_onehot && (cnt_q[bal_idx] != CNT_MAX)) begin
                            cnt_d[bal_idx] = cnt_q[bal_idx] + 1'b1;
                            total_d        = total_q + 1'b1;
                            auto_close     = (total_q + 1'b1) == MAX_T;
                        end else if (rej_q != CNT_MAX) begin
                            rej_d = rej_q + 1'b1;
                        end
                    end
                    // The ballot above is already folded in before the phase change.
                    if (cmd_close || auto_close) begin
                        state_d    = ST_TALLY;
                        scan_cnt_d = '0;
                        max_d      = '0;
                        max_idx_d  = '0;
                        scan_tie_d = 1'b0;
                    end
                end
                ST_TALLY: begin
                    if (scan_cnt_q == SCAN_END) begin
                        winner_d = ((max_q != '0) && !scan_tie_q)
                                   ? (NUM_CAND'(1) << max_idx_q) : '0;
                        tie_d    = (max_q != '0) && scan_tie_q;
                        state_d  = ST_DONE;
                    end else begin
                        scan_val = cnt_q[scan_idx];
                        if (scan_val > max_q) begin
                            max_d      = scan_val;
                            max_idx_d  = scan_idx;
                            scan_tie_d = 1'b0;
                        end else if ((scan_val == max_q) && (max_q != '0)) begin
                            scan_tie_d = 1'b1;
                        end
                        scan_cnt_d = scan_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt_q[i] <= '0;
            end
            total_q    <= '0;
            rej_q      <= '0;
            rd_count_q <= '0;
            winner_q   <= '0;
            tie_q      <= 1'b0;
            scan_cnt_q <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            scan_tie_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            total_q    <= total_d;
            rej_q      <= rej_d;
            rd_count_q <= rd_count_d;
            winner_q   <= winner_d;
            tie_q      <= tie_d;
            scan_cnt_q <= scan_cnt_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            scan_tie_q <= scan_tie_d;
        end
    end

    assign ballot_ready_o = (state_q == ST_OPEN);
    assign result_valid_o = (state_q == ST_DONE);
    assign state_o        = state_q;
    assign rd_count_o     = rd_count_q;
    assign total_o        = total_q;
    assign rejected_o     = rej_q;
    assign winner_o       = winner_q;
    assign tie_o          = tie_q;

endmodule

// File: doc/vote_tally_core.md
# vote_tally_core

Parametrised ballot-tally engine for the voting machine family. It accepts one-hot ballots for `NUM_CAND` candidates through a valid/ready handshake and keeps a saturating counter per candidate. Invalid ballots are counted separately. An election-phase FSM closes the vote, either on command or automatically at a ballot limit, then runs a sequential tally scan that produces a one-hot winner and a tie flag. It sits between the front-panel input conditioning and the display/readout logic, and replaces the fixed 4-candidate counter.

## Interface
Parameters:
- `NUM_CAND`, 4: number of candidates, from 2 to 16.
- `CNT_W`, 8: width of each per-candidate counter and of the reject counter.
- `MAX_BALLOTS`, 200: accepted-ballot limit that forces auto-close. Range 1 to 2^TOT_W-1.
- `IDX_W` = $clog2(NUM_CAND) and `TOT_W` = CNT_W+IDX_W (derived).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  qualifies `cmd` for one cycle.
- `cmd`  in  2  00=OPEN, 01=CLOSE, 10=CLEAR, 11=NOP.
- `ballot_valid`  in  1  a ballot is presented.
- `ballot`  in  NUM_CAND  one-hot candidate select.
- `ballot_ready`  out  1  equals 1 exactly while state is OPEN.
- `rd_idx`  in  IDX_W  selects the candidate counter to read back.
- `rd_count`  out  CNT_W  registered counter value for `rd_idx`.
- `state`  out  2  00=IDLE, 01=OPEN, 10=TALLY, 11=DONE.
- `total`  out  TOT_W  number of accepted ballots.
- `rejected`  out  CNT_W  number of rejected ballots; saturates at all-ones.
- `winner`  out  NUM_CAND  one-hot winner; 0 on no votes or on a tie.
- `tie`  out  1  set when 2 or more candidates share a nonzero maximum.
- `result_valid`  out  1  equals 1 exactly while state is DONE.

## Operation
- Reset: state=IDLE. All counters, `total`, `rejected`, `rd_count`, `winner`, `tie` and `result_valid` are 0.
- CLEAR (any state):
  - Zeroes all counters, `total`, `rejected`, `winner` and `tie`.
  - Next state is IDLE.
  - CLEAR has top priority; a ballot presented in the same cycle is dropped and not counted.
- IDLE: OPEN moves to OPEN. CLOSE and NOP are ignored.
- OPEN: a ballot is accepted on a cycle where `ballot_valid` and `ballot_ready` are both 1.
  - Exactly one bit set, and that candidate's counter is below 2^CNT_W-1: the counter increments and `total` increments.
  - Exactly one bit set, but that candidate's counter is saturated: the ballot is rejected. `rejected` increments; the counter and `total` are unchanged.
  - Zero bits or more than one bit set: the ballot is rejected and `rejected` increments.
- Leaving OPEN:
  - CLOSE moves to TALLY.
  - Auto-close: when an accepted ballot makes `total`==MAX_BALLOTS, the next state is TALLY.
  - If CLOSE and a ballot arrive in the same cycle, the ballot is processed first, then the state moves to TALLY.
- OPEN command in OPEN, TALLY or DONE: ignored.
- TALLY: scans candidates i=0..NUM_CAND-1, one per cycle, holding a running max, a max index and a tie flag.
  - counter > max: max=counter, index=i, tie=0.
  - counter == max and max != 0: tie=1.
  - After index NUM_CAND-1 has been scanned, the result registers load and the state moves to DONE.
  - `winner` is the one-hot of the index when max != 0 and tie=0; otherwise `winner` is 0.
  - `tie` is output only when max != 0.
  - CLOSE is ignored during TALLY.
- DONE: the result holds until CLEAR. Counters stay readable through `rd_count`.
- Arithmetic:
  - Every counter saturates and never wraps.
  - `total` cannot exceed MAX_BALLOTS because auto-close occurs first.

## Timing
- A ballot accepted at edge k is visible in its counter and in `total` from k+1.
- `rd_count` has 1-cycle latency: `rd_idx` sampled at edge k appears at k+1. Read-back works in every state.
- CLOSE or auto-close at edge k gives state=TALLY from k+1 and state=DONE after NUM_CAND further cycles, with `result_valid` and `winner` valid together. Example: NUM_CAND=4, CLOSE at edge 10, DONE at edge 15.
- Commands take effect at the edge where `cmd_valid`=1. Commands are level-sampled, not edge-detected; the upstream block supplies single-cycle pulses.
- `rst_n` assertion at any point, including mid-TALLY, forces the reset values immediately. Deassertion is synchronised externally.

## Test plan
- Basic vote. Defaults; OPEN; ballots 0001 ×3, 0100 ×1; CLOSE. Required: counters 3,0,1,0; total=4; DONE at CLOSE+5; winner=0001; tie=0.
- Tie. Ballots 0010 ×2 and 1000 ×2, then CLOSE. Required: winner=0000, tie=1. A separate run with no ballots, then CLOSE, requires winner=0000 and tie=0.
- Invalid and saturating ballots. CNT_W=2; ballots 0000, 0011 and 0001 ×4. Required: counter0=3, rejected=3, total=3.
- Auto-close. MAX_BALLOTS=5; ballot_valid held with 0001. Required: exactly 5 accepted, `ballot_ready` drops the cycle after the 5th acceptance, then state=TALLY.
- Simultaneous events:
  - CLOSE with a valid ballot in the same cycle: the ballot is counted, then TALLY.
  - CLEAR with a valid ballot in the same cycle: the ballot is not counted; state=IDLE and all counters are 0.
- Reset mid-TALLY. Assert `rst_n`=0 on the 2nd TALLY cycle. Required: state=IDLE with all outputs 0 immediately. After re-open, the tally is correct.
